// File: rtl/digitization_sequencer.sv
// Wilkinson digitization sequencer: SETUP -> RAMP -> SETTLE -> DONE, all outputs registered.
// First SETUP cycle one cycle after start_i; starts while busy are dropped and flagged in overrun_o.
module digitization_sequencer #(
   parameter int SETUP_CYCLES = 4,
   parameter int CNT_W        = 12
) (
   input  logic             s00_axi_aclk,
   input  logic             s00_axi_aresetn,
   input  logic             start_i,
   input  logic [8:0]       window_i,
   input  logic [CNT_W-1:0] ramp_len_i,
   input  logic             clr_status_i,
   output logic [8:0]       rd_addr_o,
   output logic             rd_ena_o,
   output logic             clr_o,
   output logic             ramp_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             overrun_o
);

   typedef enum logic [2:0] {IDLE, SETUP, RAMP, SETTLE, DONE} state_t;

   localparam logic [7:0]       SETUP_LAST = 8'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LEN_ONE    = CNT_W'(1);

   state_t           state_q, state_d;
   logic [7:0]       setup_cnt_q, setup_cnt_d;
   logic [CNT_W-1:0] ramp_cnt_q, ramp_cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [8:0]       addr_q, addr_d;
   logic             overrun_q, overrun_d;
   logic             rd_ena_q, rd_ena_d;
   logic             clr_q, clr_d;
   logic             ramp_q, ramp_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d     = state_q;
      setup_cnt_d = setup_cnt_q;
      ramp_cnt_d  = ramp_cnt_q;
      len_d       = len_q;
      addr_d      = addr_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d     = SETUP;
               setup_cnt_d = SETUP_LAST;
               addr_d      = window_i;
               // A zero-length ramp would never convert; treat it as one cycle.
               len_d       = (ramp_len_i == '0) ? LEN_ONE : ramp_len_i;
            end
         end
         SETUP: begin
            if (setup_cnt_q == '0) begin
               state_d    = RAMP;
               ramp_cnt_d = len_q - LEN_ONE;
            end else begin
               setup_cnt_d = setup_cnt_q - 8'd1;
            end
         end
         RAMP: begin
            if (ramp_cnt_q == '0) begin
               state_d = SETTLE;
            end else begin
               ramp_cnt_d = ramp_cnt_q - LEN_ONE;
            end
         end
         SETTLE:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered pins line up with state_q.
   always_comb begin
      rd_ena_d = (state_d == SETUP) || (state_d == RAMP) || (state_d == SETTLE);
      clr_d    = (state_d == SETUP);
      ramp_d   = (state_d == RAMP);
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
   end

   // A start that lands while busy outranks a simultaneous status clear.
   always_comb begin
      overrun_d = overrun_q;
      if (start_i && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end else if (clr_status_i) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_q     <= IDLE;
         setup_cnt_q <= '0;
         ramp_cnt_q  <= '0;
         len_q       <= '0;
         addr_q      <= '0;
         overrun_q   <= 1'b0;
         rd_ena_q    <= 1'b0;
         clr_q       <= 1'b0;
         ramp_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         setup_cnt_q <= setup_cnt_d;
         ramp_cnt_q  <= ramp_cnt_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         overrun_q   <= overrun_d;
         rd_ena_q    <= rd_ena_d;
         clr_q       <= clr_d;
         ramp_q      <= ramp_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rd_addr_o = addr_q;
   assign rd_ena_o  = rd_ena_q;
   assign clr_o     = clr_q;
   assign ramp_o    = ramp_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign overrun_o = overrun_q;

endmodule
